if_id_reg: RTL and testbench
============================

# if_id_reg

Fetch-to-decode pipeline register of the P7 MIPS core. It sits directly downstream of the PC register and instruction memory. Each cycle it captures the fetched PC, the instruction word and the delay-slot flag, and it detects fetch-address exceptions. It applies stall, flush and exception-request (Req) control so that the decode stage always sees either a valid instruction or a well-defined bubble.

## Interface
Parameters:
- PC_RESET, 32'h0000_3000, D_pc value after reset
- EXC_ENTRY, 32'h0000_4180, D_pc value after Req
- IM_BASE, 32'h0000_3000, lowest legal fetch address
- IM_TOP, 32'h0000_6FFC, highest legal fetch address

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- Req  in  1  exception/interrupt taken this cycle; kills the F-stage instruction
- en  in  1  1 = advance, 0 = stall (hold contents)
- flush  in  1  kill the F-stage instruction (asserted for eret in D)
- F_pc  in  32  PC of the instruction in fetch
- F_instr  in  32  instruction word read from IM at F_pc
- F_bd  in  1  F-stage instruction is in a branch delay slot
- D_pc  out  32  PC of the decode-stage instruction
- D_instr  out  32  decode-stage instruction (32'h0 = nop/bubble)
- D_exccode  out  5  pending exception code (0 = none, 4 = AdEL)
- D_bd  out  1  delay-slot flag for the decode-stage instruction
- D_valid  out  1  1 = real instruction, 0 = bubble

## Operation
- Fetch check is combinational on F_pc. The fetch is illegal when F_pc[1:0] != 0, or F_pc < IM_BASE, or F_pc > IM_TOP.
- Update priority per edge, highest first:
  - reset: D_pc=PC_RESET, D_instr=0, D_exccode=0, D_bd=0, D_valid=0.
  - Req: D_pc=EXC_ENTRY, D_instr=0, D_exccode=0, D_bd=0, D_valid=0.
  - en=0: all outputs hold. A stall overrides flush; because the eret stays in D, flush remains asserted until the stall releases.
  - flush: D_pc=F_pc, D_instr=0, D_exccode=0, D_bd=0, D_valid=0.
  - Normal load, illegal fetch: D_pc=F_pc, D_instr=0, D_exccode=4 (AdEL), D_bd=F_bd, D_valid=1. The instruction stays valid so that the exception reaches the M stage with the correct EPC and BD.
  - Normal load, legal fetch: D_pc=F_pc, D_instr=F_instr, D_exccode=0, D_bd=F_bd, D_valid=1.
- Bubbles keep a meaningful D_pc, so macro-PC/EPC logic downstream never sees 0.
- No arithmetic on the PC. Range compares are unsigned, full 32-bit.

## Timing
- Latency: 1 cycle from F inputs to D outputs.
- All outputs are registered. No combinational path from inputs to outputs.
- Req and reset in the same cycle: reset wins.
- Req during a stall: Req wins (Req overrides en=0).
- flush together with an illegal F_pc: a bubble results with D_exccode=0; the killed fetch raises no exception.
- A stall that lasts N cycles holds the outputs bit-identical for N cycles.
- Reset mid-stall: outputs go to reset values on that edge.

## Structure
- Shared package cpu_defs holds PC_RESET, EXC_ENTRY, IM_BASE, IM_TOP, EXC_ADEL=5'd4, EXC_NONE=5'd0 and NOP=32'h0. The PC, M-stage CP0 and this block all import it.
- One natural sub-module: fetch_addr_check (combinational, F_pc -> illegal).

## Test plan
- Reset held 2 cycles, then released with F_pc=0x3000, F_instr=0x3C010001, en=1 -> D_pc=0x3000, D_instr=0, D_valid=0 after reset; next edge D_instr=0x3C010001, D_valid=1, D_exccode=0.
- en=0 for 3 cycles while F_pc changes 0x3004 -> 0x3008 -> 0x300C -> D outputs frozen at their 0x3004 contents for 3 edges.
- F_pc=0x3002, F_bd=1 -> D_instr=0, D_exccode=4, D_bd=1, D_valid=1. Repeat with F_pc=0x7000 and F_pc=0x2FFC -> D_exccode=4. F_pc=0x6FFC -> D_exccode=0.
- flush=1 with F_pc=0x3010, F_instr=0x00000008 -> D_pc=0x3010, D_instr=0, D_valid=0. Then flush=1 with en=0 -> hold.
- Req=1 with en=0 and F_pc=0x3020 -> D_pc=0x4180, D_instr=0, D_bd=0. Req=1 with reset=1 -> D_pc=0x3000.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared P7 core constants: fetch window, reset/exception PCs and exception codes.
package cpu_defs;

  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
  localparam logic [31:0] IM_BASE   = 32'h0000_3000;
  localparam logic [31:0] IM_TOP    = 32'h0000_6FFC;

  localparam logic [4:0]  EXC_NONE  = 5'd0;
  localparam logic [4:0]  EXC_ADEL  = 5'd4;
  localparam logic [31:0] NOP       = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exccode;
    logic        bd;
    logic        valid;
  } d_stage_t;

endpackage

// File: rtl/if_id_reg_if.sv
// F-to-D pipeline register bundle: fetch-side inputs, control, and decode-side outputs.
interface if_id_reg_if;

  logic        Req;
  logic        en;
  logic        flush;
  logic [31:0] F_pc;
  logic [31:0] F_instr;
  logic        F_bd;
  logic [31:0] D_pc;
  logic [31:0] D_instr;
  logic [4:0]  D_exccode;
  logic        D_bd;
  logic        D_valid;

  modport master (
    output Req, en, flush, F_pc, F_instr, F_bd,
    input  D_pc, D_instr, D_exccode, D_bd, D_valid
  );

  modport slave (
    input  Req, en, flush, F_pc, F_instr, F_bd,
    output D_pc, D_instr, D_exccode, D_bd, D_valid
  );

endinterface

// File: rtl/if_id_reg_fetch_addr_check.sv
// Combinational fetch-address legality check: misaligned or outside the IM window.
module fetch_addr_check #(
    parameter logic [31:0] IM_BASE = cpu_defs::IM_BASE,
    parameter logic [31:0] IM_TOP  = cpu_defs::IM_TOP
) (
    input  logic [31:0] F_pc,
    output logic        illegal
);

    always_comb begin
        illegal = (F_pc[1:0] != 2'b00) || (F_pc < IM_BASE) || (F_pc > IM_TOP);
    end

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall, flush, exception-request and AdEL detection.
module if_id_reg
    import cpu_defs::*;
#(
    parameter logic [31:0] PC_RESET  = cpu_defs::PC_RESET,
    parameter logic [31:0] EXC_ENTRY = cpu_defs::EXC_ENTRY,
    parameter logic [31:0] IM_BASE   = cpu_defs::IM_BASE,
    parameter logic [31:0] IM_TOP    = cpu_defs::IM_TOP
) (
    input logic         clk,
    input logic         reset,
    if_id_reg_if.slave  bus
);

    d_stage_t dstage_d;
    d_stage_t dstage_q;
    logic     illegal;

    fetch_addr_check #(
        .IM_BASE (IM_BASE),
        .IM_TOP  (IM_TOP)
    ) u_fetch_addr_check (
        .F_pc    (bus.F_pc),
        .illegal (illegal)
    );

    // Bubbles still carry a real PC so downstream EPC logic never sees 0.
    always_comb begin
        dstage_d = dstage_q;
        if (reset) begin
            dstage_d = '{pc: PC_RESET, instr: NOP, exccode: EXC_NONE, bd: 1'b0, valid: 1'b0};
        end else if (bus.Req) begin
            dstage_d = '{pc: EXC_ENTRY, instr: NOP, exccode: EXC_NONE, bd: 1'b0, valid: 1'b0};
        end else if (!bus.en) begin
            dstage_d = dstage_q;
        end else if (bus.flush) begin
            dstage_d = '{pc: bus.F_pc, instr: NOP, exccode: EXC_NONE, bd: 1'b0, valid: 1'b0};
        end else if (illegal) begin
            // Kept valid so the AdEL reaches M with the right EPC and BD.
            dstage_d = '{pc: bus.F_pc, instr: NOP, exccode: EXC_ADEL, bd: bus.F_bd, valid: 1'b1};
        end else begin
            dstage_d = '{pc: bus.F_pc, instr: bus.F_instr, exccode: EXC_NONE, bd: bus.F_bd,
                         valid: 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        dstage_q <= dstage_d;
    end

    assign bus.D_pc      = dstage_q.pc;
    assign bus.D_instr   = dstage_q.instr;
    assign bus.D_exccode = dstage_q.exccode;
    assign bus.D_bd      = dstage_q.bd;
    assign bus.D_valid   = dstage_q.valid;

endmodule

// File: tb/tb_if_id_reg.sv
// Bench for if_id_reg: directed test-plan sequence then randomized traffic vs. a reference model.
module tb_if_id_reg;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    if_id_reg_if bus ();

    if_id_reg u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: what decode should hold.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [4:0]  m_exc;
    logic        m_bd;
    logic        m_valid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit fetch_bad(input logic [31:0] pc);
        return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFC);
    endfunction

    // Decide what the edge should do from the rule table, then apply it to the model.
    task automatic model_edge(input logic rst, input logic req, input logic en, input logic fl,
                              input logic [31:0] pc, input logic [31:0] ins, input logic bd);
        if (rst) begin
            m_pc = 32'h3000; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
        end else if (req) begin
            m_pc = 32'h4180; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
        end else if (en && fl) begin
            m_pc = pc; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
        end else if (en) begin
            m_pc    = pc;
            m_instr = fetch_bad(pc) ? 32'h0 : ins;
            m_exc   = fetch_bad(pc) ? 5'd4 : 5'd0;
            m_bd    = bd;
            m_valid = 1;
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic req, input logic en,
                        input logic fl, input logic [31:0] pc, input logic [31:0] ins,
                        input logic bd);
        reset = rst; bus.Req = req; bus.en = en; bus.flush = fl;
        bus.F_pc = pc; bus.F_instr = ins; bus.F_bd = bd;
        @(posedge clk);
        #1;
        model_edge(rst, req, en, fl, pc, ins, bd);
        check({tag, ".pc"},    bus.D_pc,    m_pc);
        check({tag, ".instr"}, bus.D_instr, m_instr);
        check({tag, ".ctl"},   {25'd0, bus.D_exccode, bus.D_bd, bus.D_valid},
                               {25'd0, m_exc, m_bd, m_valid});
    endtask

    function automatic logic [31:0] rand_pc();
        case ($urandom_range(0, 7))
            0:       return 32'h3000 + ({20'd0, 12'($urandom_range(0, 4095))} << 2) + 
                            32'($urandom_range(1, 3));
            1:       return 32'($urandom_range(0, 32'h2FFF));
            2:       return 32'h7000 + 32'($urandom_range(0, 32'hFFFF));
            3:       return ($urandom_range(0, 1) != 0) ? 32'h6FFC : 32'h3000;
            4:       return ($urandom_range(0, 1) != 0) ? 32'h7000 : 32'h2FFC;
            default: return 32'h3000 + ({20'd0, 12'($urandom_range(0, 4095))} << 2);
        endcase
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_pc = 0; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;

        // Reset held two cycles, then the first real fetch.
        step("rst0", 1, 0, 1, 0, 32'h3000, 32'h3C01_0001, 0);
        step("rst1", 1, 0, 1, 0, 32'h3000, 32'h3C01_0001, 0);
        check("rst.valid", {31'd0, bus.D_valid}, 32'd0);
        step("load0", 0, 0, 1, 0, 32'h3000, 32'h3C01_0001, 0);
        check("load0.instr_lit", bus.D_instr, 32'h3C01_0001);

        // Load 0x3004, then stall three cycles with F_pc moving.
        step("load1", 0, 0, 1, 0, 32'h3004, 32'h2402_0005, 0);
        step("stall0", 0, 0, 0, 0, 32'h3008, 32'h1111_1111, 1);
        step("stall1", 0, 0, 0, 0, 32'h300C, 32'h2222_2222, 0);
        step("stall2", 0, 0, 0, 0, 32'h3010, 32'h3333_3333, 1);
        check("stall.pc_lit", bus.D_pc, 32'h3004);

        // Address errors and the top boundary.
        step("adel_mis", 0, 0, 1, 0, 32'h3002, 32'hDEAD_BEEF, 1);
        check("adel_mis.exc_lit", {27'd0, bus.D_exccode}, 32'd4);
        step("adel_hi",  0, 0, 1, 0, 32'h7000, 32'hDEAD_BEEF, 0);
        step("adel_lo",  0, 0, 1, 0, 32'h2FFC, 32'hDEAD_BEEF, 0);
        step("top_ok",   0, 0, 1, 0, 32'h6FFC, 32'h0000_000C, 0);

        // Flush, flush under stall, flush with an illegal PC.
        step("flush",     0, 0, 1, 1, 32'h3010, 32'h0000_0008, 0);
        step("flush_stl", 0, 0, 0, 1, 32'h3014, 32'h0000_0009, 1);
        step("flush_bad", 0, 0, 1, 1, 32'h3001, 32'h0000_0009, 1);

        // Req during a stall, Req with reset.
        step("load2",   0, 0, 1, 0, 32'h3018, 32'h0000_0020, 1);
        step("req_stl", 0, 1, 0, 0, 32'h3020, 32'h0000_0021, 1);
        check("req.pc_lit", bus.D_pc, 32'h4180);
        step("req_rst", 1, 1, 1, 0, 32'h3024, 32'h0000_0022, 0);
        check("req_rst.pc_lit", bus.D_pc, 32'h3000);

        // Randomized traffic; reset mid-stall and Req-in-stall occur naturally.
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0),
                 rand_pc(), $urandom(), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
